// File: rtl/uart_byte_rx_if.sv
// Byte-side interface of the UART receiver: received byte, valid/ready handshake
// and the two error pulses.
interface uart_byte_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_err,
    output overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_err,
    input  overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: centre-of-bit sampling from a cycle counter, valid/ready byte
// output with one-cycle framing-error and overrun pulses.
module uart_byte_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rx,
  uart_byte_rx_if.master  rx_if
);

  localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CYC_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] CYC_HALF = 16'(CYCLE / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_REC   = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  rx_sync_q;
  logic        rx_dly_q;
  logic [15:0] cycle_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;

  logic rx_s;
  logic start_edge_s;
  logic cnt_half_s;
  logic cnt_last_s;
  logic handshake_s;

  assign rx_s         = rx_sync_q[1];
  assign start_edge_s = rx_dly_q & ~rx_s;
  assign cnt_half_s   = (cycle_cnt_q == CYC_HALF);
  assign cnt_last_s   = (cycle_cnt_q == CYC_LAST);
  assign handshake_s  = valid_q & rx_if.rx_data_ready;

  // Synchronizer plus delay flop; reset high so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_dly_q  <= rx_sync_q[1];
    end
  end

  // Frame FSM with registered byte/handshake/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (handshake_s) begin
        valid_q <= 1'b0;
      end
      if ((state_q == S_IDLE) || cnt_last_s) begin
        cycle_cnt_q <= 16'd0;
      end else begin
        cycle_cnt_q <= cycle_cnt_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= 3'd0;
          if (start_edge_s) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          // A start bit already high again at its centre was only a glitch.
          if (cnt_half_s && rx_s) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= 16'd0;
          end else if (cnt_last_s) begin
            state_q <= S_REC;
          end
        end
        S_REC: begin
          if (cnt_half_s) begin
            shift_q[bit_cnt_q] <= rx_s;
          end
          if (cnt_last_s) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          // Leave at mid-stop so a start edge in the second half of the stop bit is caught.
          if (cnt_half_s) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= 16'd0;
            if (rx_s) begin
              rx_data_q <= shift_q;
              valid_q   <= 1'b1;
              overrun_q <= valid_q & ~rx_if.rx_data_ready;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data       = rx_data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.frame_err     = frame_err_q;
  assign rx_if.overrun       = overrun_q;

endmodule
